// File: rtl/regwr_arbiter_pkg.sv
// ============================================================================
// Module   : regwr_arbiter_pkg
// Purpose  : Shared widths, write-enable levels and grant encoding for the
//            regfile write-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package regwr_arbiter_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int RADDR_WIDTH     = 5;
    localparam int LATE_FIFO_DEPTH = 2;
    localparam int DEF_STARVE_LIMIT = 4;

    localparam logic REG_WR_EN  = 1'b1;
    localparam logic REG_WR_DIS = 1'b0;

    localparam logic [RADDR_WIDTH-1:0] R_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0]  ZERO   = '0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_HEAD = 2'd2
    } grant_e;

    function automatic logic [31:0] onehot32(input logic [RADDR_WIDTH-1:0] a);
        return 32'(1) << a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_late_fifo.sv
// ============================================================================
// Module   : wb_late_fifo
// Purpose  : Late-return buffer with per-entry kill bits and address-match
//            kill so younger pipeline writes can squash stale entries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_late_fifo
    import regwr_arbiter_pkg::*;
#(
    parameter int DEPTH = LATE_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [RADDR_WIDTH-1:0]       i_push_waddr,
    input  logic [DATA_WIDTH-1:0]        i_push_wdata,
    input  logic                         i_push_kill,
    input  logic                         i_pop,
    input  logic                         i_kill_en,
    input  logic [RADDR_WIDTH-1:0]       i_kill_addr,
    output logic [RADDR_WIDTH-1:0]       o_head_waddr,
    output logic [DATA_WIDTH-1:0]        o_head_wdata,
    output logic                         o_head_kill,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [DEPTH-1:0]             o_live,
    output logic [DEPTH*RADDR_WIDTH-1:0] o_entry_waddr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = (AW+1)'(1);

    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [DEPTH-1:0]       r_valid;
    logic [DEPTH-1:0]       r_kill;
    logic [RADDR_WIDTH-1:0] r_waddr [DEPTH];
    logic [DATA_WIDTH-1:0]  r_wdata [DEPTH];

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Extra wrap bit distinguishes full from empty when the indices coincide.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign o_head_waddr = r_waddr[w_rd_idx];
    assign o_head_wdata = r_wdata[w_rd_idx];
    assign o_head_kill  = r_kill[w_rd_idx];
    assign o_live       = r_valid & ~r_kill;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_addr
        assign o_entry_waddr[g*RADDR_WIDTH +: RADDR_WIDTH] = r_waddr[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            r_kill   <= '0;
        end else begin
            if (i_kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_valid[i] && (r_waddr[i] == i_kill_addr)) begin
                        r_kill[i] <= 1'b1;
                    end
                end
            end
            if (i_pop) begin
                r_valid[w_rd_idx] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PTR_ONE;
            end
            // Push is never issued when full, so it cannot collide with the popped slot.
            if (i_push) begin
                r_waddr[w_wr_idx] <= i_push_waddr;
                r_wdata[w_wr_idx] <= i_push_wdata;
                r_kill[w_wr_idx]  <= i_push_kill;
                r_valid[w_wr_idx] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regwr_arbiter.sv
// ============================================================================
// Module   : regwr_arbiter
// Purpose  : Shares the regfile write port between in-order writeback and
//            buffered late load returns, with a starvation stall and busy mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regwr_arbiter
    import regwr_arbiter_pkg::*;
#(
    parameter int DEPTH        = LATE_FIFO_DEPTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pipe_we,
    input  logic [RADDR_WIDTH-1:0] pipe_waddr,
    input  logic [DATA_WIDTH-1:0]  pipe_wdata,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [RADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0]  lsu_wdata,
    output logic                   pipe_stall,
    output logic                   rf_we,
    output logic [RADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata,
    output logic [31:0]            busy_mask
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] c_AGE_MAX = AGE_W'(STARVE_LIMIT - 1);
    localparam logic [AGE_W-1:0] c_AGE_ONE = AGE_W'(1);

    logic             r_stall;
    logic [AGE_W-1:0] r_age;

    grant_e                       w_grant;
    logic                         w_pipe_gnt;
    logic                         w_head_gnt;
    logic                         w_push;
    logic                         w_push_kill;
    logic                         w_stall_nxt;
    logic [RADDR_WIDTH-1:0]       w_head_waddr;
    logic [DATA_WIDTH-1:0]        w_head_wdata;
    logic                         w_head_kill;
    logic                         w_empty;
    logic                         w_full;
    logic [DEPTH-1:0]             w_live;
    logic [DEPTH*RADDR_WIDTH-1:0] w_entry_waddr;

    wb_late_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_push_waddr  (lsu_waddr),
        .i_push_wdata  (lsu_wdata),
        .i_push_kill   (w_push_kill),
        .i_pop         (w_head_gnt),
        .i_kill_en     (w_pipe_gnt),
        .i_kill_addr   (pipe_waddr),
        .o_head_waddr  (w_head_waddr),
        .o_head_wdata  (w_head_wdata),
        .o_head_kill   (w_head_kill),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_live        (w_live),
        .o_entry_waddr (w_entry_waddr)
    );

    // A stall cycle belongs to the buffer head; pipe_* is ignored entirely.
    always_comb begin
        w_grant = GNT_NONE;
        if (r_stall) begin
            if (!w_empty) begin
                w_grant = GNT_HEAD;
            end
        end else if ((pipe_we == REG_WR_EN) && (pipe_waddr != R_ZERO)) begin
            w_grant = GNT_PIPE;
        end else if (!w_empty) begin
            w_grant = GNT_HEAD;
        end
    end

    assign w_pipe_gnt  = (w_grant == GNT_PIPE);
    assign w_head_gnt  = (w_grant == GNT_HEAD);
    assign w_push      = lsu_valid && !w_full && (lsu_waddr != R_ZERO);
    assign w_push_kill = w_pipe_gnt && (pipe_waddr == lsu_waddr);
    assign lsu_ready   = !w_full;
    assign pipe_stall  = r_stall;

    assign w_stall_nxt = !r_stall &&
                         ((!w_empty && !w_head_gnt && (r_age == c_AGE_MAX)) ||
                          (w_full && lsu_valid));

    always_comb begin
        rf_we    = REG_WR_DIS;
        rf_waddr = R_ZERO;
        rf_wdata = ZERO;
        if (rst_n) begin
            if (w_pipe_gnt) begin
                rf_we    = REG_WR_EN;
                rf_waddr = pipe_waddr;
                rf_wdata = pipe_wdata;
            end else if (w_head_gnt && !w_head_kill) begin
                rf_we    = REG_WR_EN;
                rf_waddr = w_head_waddr;
                rf_wdata = w_head_wdata;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i]) begin
                busy_mask = busy_mask | onehot32(w_entry_waddr[i*RADDR_WIDTH +: RADDR_WIDTH]);
            end
        end
        busy_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall <= 1'b0;
            r_age   <= '0;
        end else begin
            r_stall <= w_stall_nxt;
            r_age   <= (w_empty || w_head_gnt) ? '0 : (r_age + c_AGE_ONE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
// ============================================================================
// Module   : tb_regwr_arbiter
// Purpose  : Directed and random stimulus for regwr_arbiter against a
//            queue-based reference of the write-port sharing rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regwr_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        k;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr;
    logic [31:0] lsu_wdata;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    bit   m_stall = 1'b0;
    int   m_age   = 0;

    always #5 clk = ~clk;

    regwr_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_waddr  (lsu_waddr),
        .lsu_wdata  (lsu_wdata),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy_mask  (busy_mask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we    = pw;
        pipe_waddr = pa;
        pipe_wdata = pd;
        lsu_valid  = lv;
        lsu_waddr  = la;
        lsu_wdata  = ld;
        #1;
    endtask

    // Compare this cycle against the reference, then advance it across the edge.
    task automatic tick();
        logic        exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        logic [31:0] exp_busy;
        bit          full, empty, pg, hg, nstall;
        ent_t        e;
        #1;
        if (!rst_n) begin
            chk("rst_rf_we", rf_we, 0);
            q.delete();
            m_stall = 1'b0;
            m_age   = 0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            exp_busy = '0;
            foreach (q[i]) if (!q[i].k) exp_busy = exp_busy | (32'(1) << q[i].a);
            exp_busy[0] = 1'b0;
            pg = 1'b0;
            hg = 1'b0;
            if (m_stall) hg = !empty;
            else if (pipe_we && pipe_waddr != 5'd0) pg = 1'b1;
            else hg = !empty;
            exp_we = 1'b0;
            exp_a  = '0;
            exp_d  = '0;
            if (pg) begin
                exp_we = 1'b1; exp_a = pipe_waddr; exp_d = pipe_wdata;
            end else if (hg && !q[0].k) begin
                exp_we = 1'b1; exp_a = q[0].a; exp_d = q[0].d;
            end
            chk("rf_we", rf_we, exp_we);
            chk("rf_waddr", rf_waddr, exp_a);
            chk("rf_wdata", rf_wdata, exp_d);
            chk("lsu_ready", lsu_ready, !full);
            chk("pipe_stall", pipe_stall, m_stall);
            chk("busy_mask", busy_mask, exp_busy);

            if (pg) foreach (q[i]) if (q[i].a == pipe_waddr) q[i].k = 1'b1;
            nstall = !m_stall && ((!empty && !hg && m_age == LIMIT - 1) || (full && lsu_valid));
            m_age  = (empty || hg) ? 0 : m_age + 1;
            if (hg) void'(q.pop_front());
            if (lsu_valid && !full && lsu_waddr != 5'd0) begin
                e.a = lsu_waddr;
                e.d = lsu_wdata;
                e.k = pg && (pipe_waddr == lsu_waddr);
                q.push_back(e);
            end
            m_stall = nstall;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 5'd3, 32'h1234, 1, 5'd4, 32'h4444);
        chk("reset_rf_we", rf_we, 0);
        tick();
        tick();

        // Reset state
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("reset_ready", lsu_ready, 1);
        chk("reset_busy", busy_mask, 0);
        chk("reset_stall", pipe_stall, 0);
        tick();

        // Idle drain
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("drain_we", rf_we, 1);
        chk("drain_addr", rf_waddr, 5);
        chk("drain_data", rf_wdata, 32'hDEADBEEF);
        chk("drain_busy5", busy_mask[5], 1);
        tick();
        chk("drain_busy_clr", busy_mask[5], 0);
        tick();

        // Starvation guard
        drive(1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 5'd3, 32'h33 + i, 0, 0, 0);
            chk("starve_stall", pipe_stall, (i == 4));
            if (i == 4) chk("starve_addr", rf_waddr, 7);
            if (i == 5) chk("starve_pipe_back", rf_waddr, 3);
            tick();
        end

        // WAW squash
        drive(1, 5'd3, 32'h30, 1, 5'd9, 32'h11);
        tick();
        drive(1, 5'd9, 32'h22, 0, 0, 0);
        chk("waw_busy_before", busy_mask[9], 1);
        chk("waw_pipe_data", rf_wdata, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("waw_busy_after", busy_mask[9], 0);
        chk("waw_killed_head_we", rf_we, 0);
        tick();
        tick();

        // Full backpressure
        drive(1, 5'd3, 32'h40, 1, 5'd1, 32'h101);
        tick();
        drive(1, 5'd3, 32'h41, 1, 5'd2, 32'h102);
        tick();
        drive(1, 5'd3, 32'h42, 1, 5'd3, 32'h103);
        chk("full_ready", lsu_ready, 0);
        tick();
        chk("full_stall", pipe_stall, 1);
        chk("full_drain_addr", rf_waddr, 1);
        tick();
        chk("full_ready_again", lsu_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();

        // x0 handling
        drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
        chk("x0_rf_we", rf_we, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("x0_busy", busy_mask, 0);
        chk("x0_ready", lsu_ready, 1);
        tick();

        // Randomized traffic with occasional mid-operation reset
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
            tick();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
